// File: rtl/razor_pkg.sv
// Shared definitions for the Razor recovery controller: FSM states,
// pipeline-stage indices and the flush-mask helper.
package razor_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_REPLAY = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   // Stage indices, youngest (IF/ID) to oldest (MEM/WB)
   localparam logic [1:0] STG_IFID  = 2'd0;
   localparam logic [1:0] STG_IDEX  = 2'd1;
   localparam logic [1:0] STG_EXMEM = 2'd2;
   localparam logic [1:0] STG_MEMWB = 2'd3;

   // Mask with the faulting stage and every younger stage set
   function automatic logic [3:0] flush_mask(input logic [1:0] k);
      logic [3:0] m;
      m = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i <= 32'(k)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/razor_err_prio_enc.sv
// Oldest-first priority encoder over the four stage error lines.
// Produces the winning stage index and the matching flush mask.
module razor_err_prio_enc
   import razor_pkg::*;
(
   input  logic [3:0] err,
   output logic       any,
   output logic [1:0] idx,
   output logic [3:0] mask
);

   // Highest index (oldest stage) wins on simultaneous errors
   always_comb begin
      any = |err;
      idx = STG_IFID;
      if (err[3])      idx = STG_MEMWB;
      else if (err[2]) idx = STG_EXMEM;
      else if (err[1]) idx = STG_IDEX;
      mask = flush_mask(idx);
   end

endmodule

// File: rtl/razor_recovery_ctrl.sv
// Razor error-path consumer: flushes faulting stages, stalls fetch,
// issues a one-cycle replay of the oldest faulting PC, and escalates to a
// sticky halt when retries inside the post-replay window pile up.
module razor_recovery_ctrl
   import razor_pkg::*;
#(
   parameter int unsigned PC_W         = 32,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned WINDOW       = 8,
   parameter int unsigned MAX_RETRY    = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        err_stage,
   input  logic [4*PC_W-1:0] pc_stage,
   output logic [3:0]        flush,
   output logic              stall,
   output logic              replay_valid,
   output logic [PC_W-1:0]   replay_pc,
   output logic              halt,
   output logic [CNT_W-1:0]  err_count
);

   state_t            state, state_nxt;
   logic [3:0]        fcnt, fcnt_nxt;
   logic [7:0]        wtimer, wtimer_nxt;
   logic [3:0]        retry, retry_nxt, retry_try;
   logic [3:0]        flush_nxt;
   logic              stall_nxt, rv_nxt, halt_nxt;
   logic [PC_W-1:0]   pc_nxt;
   logic [CNT_W-1:0]  cnt_nxt;

   logic              err_any;
   logic [1:0]        err_idx;
   logic [3:0]        err_mask;
   logic [PC_W-1:0]   pc_arr [4];

   razor_err_prio_enc u_prio (
      .err  (err_stage),
      .any  (err_any),
      .idx  (err_idx),
      .mask (err_mask)
   );

   // Unpack the flat per-stage PC bus
   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         pc_arr[i] = pc_stage[i*PC_W +: PC_W];
      end
   end

   // Next-state and next-output computation; every output is registered below
   always_comb begin
      state_nxt  = state;
      fcnt_nxt   = fcnt;
      wtimer_nxt = wtimer;
      retry_nxt  = retry;
      flush_nxt  = flush;
      stall_nxt  = stall;
      rv_nxt     = 1'b0;
      halt_nxt   = halt;
      pc_nxt     = replay_pc;
      cnt_nxt    = err_count;
      retry_try  = (wtimer != '0) ? retry + 4'd1 : 4'd1;

      case (state)
         ST_RUN: begin
            if (err_any) begin
               pc_nxt    = pc_arr[err_idx];
               retry_nxt = retry_try;
               stall_nxt = 1'b1;
               if (retry_try >= 4'(MAX_RETRY)) begin
                  state_nxt = ST_HALT;
                  flush_nxt = '1;
                  halt_nxt  = 1'b1;
               end else begin
                  state_nxt = ST_FLUSH;
                  flush_nxt = err_mask;
                  fcnt_nxt  = 4'(FLUSH_CYCLES - 1);
                  if (err_count != '1) cnt_nxt = err_count + 1'b1;
               end
            end else if (wtimer != '0) begin
               wtimer_nxt = wtimer - 8'd1;
            end
         end
         ST_FLUSH: begin
            if (fcnt == '0) begin
               flush_nxt = '0;
               rv_nxt    = 1'b1;
               state_nxt = ST_REPLAY;
            end else begin
               fcnt_nxt = fcnt - 4'd1;
            end
         end
         ST_REPLAY: begin
            stall_nxt  = 1'b0;
            wtimer_nxt = 8'(WINDOW);
            state_nxt  = ST_RUN;
         end
         ST_HALT: begin
            flush_nxt = '1;
            stall_nxt = 1'b1;
            halt_nxt  = 1'b1;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // State, timers, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_RUN;
         fcnt         <= '0;
         wtimer       <= '0;
         retry        <= '0;
         flush        <= '0;
         stall        <= 1'b0;
         replay_valid <= 1'b0;
         replay_pc    <= '0;
         halt         <= 1'b0;
         err_count    <= '0;
      end else begin
         state        <= state_nxt;
         fcnt         <= fcnt_nxt;
         wtimer       <= wtimer_nxt;
         retry        <= retry_nxt;
         flush        <= flush_nxt;
         stall        <= stall_nxt;
         replay_valid <= rv_nxt;
         replay_pc    <= pc_nxt;
         halt         <= halt_nxt;
         err_count    <= cnt_nxt;
      end
   end

endmodule
